// File: rtl/regfile_pkg.sv
// Shared register-file definitions: destination-select encodings, the hardwired
// zero index and default geometry used by decode, hazard and register-file blocks.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int ZERO_REG   = 0;

  typedef enum logic [1:0] {
    DEST_RT   = 2'd0,
    DEST_RD   = 2'd1,
    DEST_LINK = 2'd2,
    DEST_NONE = 2'd3
  } dest_sel_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one pending flag per register, set at load/multicycle
// issue and cleared by the writeback that delivers the result.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     set,
  input  logic [ADDR_W-1:0]        set_addr,
  input  logic                     clr,
  input  logic [ADDR_W-1:0]        clr_addr,
  input  logic [NUM_RD*ADDR_W-1:0] look_addr,
  output logic [NUM_RD-1:0]        look_busy,
  output logic                     any
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_clr;
  logic [DEPTH-1:0] busy_nxt;

  // Lookups see the clear of a same-cycle write but not a same-cycle set,
  // so a bypassed read reports the register as available.
  always_comb begin
    busy_clr = busy;
    if (clr) busy_clr[clr_addr] = 1'b0;
    busy_nxt = busy_clr;
    if (set) busy_nxt[set_addr] = 1'b1;
    busy_nxt[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) busy <= '0;
    else        busy <= busy_nxt;
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_look
    assign look_busy[p] = busy_clr[look_addr[p*ADDR_W +: ADDR_W]];
  end

  assign any = |busy;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port MIPS register file with rt/rd/link destination mux,
// write-through bypass, hardwired $0 and a busy-bit scoreboard for hazards.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int LINK_REG = 31
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [1:0]               dest_sel,
  input  logic [ADDR_W-1:0]        field_rt,
  input  logic [ADDR_W-1:0]        field_rd,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  output logic                     sb_any
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_eff;
  logic [NUM_RD-1:0] look_busy;
  dest_sel_e         dsel;

  assign dsel = dest_sel_e'(dest_sel);

  always_comb begin
    wr_addr = field_rt;
    case (dsel)
      DEST_RT:   wr_addr = field_rt;
      DEST_RD:   wr_addr = field_rd;
      DEST_LINK: wr_addr = LINK_ADDR;
      default:   wr_addr = field_rt;
    endcase
  end

  // A write only counts when it actually lands: reserved select and $0 drop it.
  assign wr_eff = wr_en && (dsel != DEST_NONE) && (wr_addr != ZERO_ADDR);

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_eff) begin
      regs[wr_addr] <= wr_data;
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD)
  ) u_sb (
    .clk       (clk),
    .reset     (reset),
    .set       (sb_set && (sb_addr != ZERO_ADDR)),
    .set_addr  (sb_addr),
    .clr       (wr_eff),
    .clr_addr  (wr_addr),
    .look_addr (rd_addr),
    .look_busy (look_busy),
    .any       (sb_any)
  );

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_p1;
    logic              busy_p1;

    assign addr = rd_addr[p*ADDR_W +: ADDR_W];

    // ---- stage p1: registered read with bypass ----
    always_ff @(posedge clk) begin
      if (!reset) begin
        data_p1 <= '0;
        busy_p1 <= 1'b0;
      end else if (rd_en[p]) begin
        if (addr == ZERO_ADDR)                data_p1 <= '0;
        else if (wr_eff && (wr_addr == addr)) data_p1 <= wr_data;
        else                                  data_p1 <= regs[addr];
        busy_p1 <= look_busy[p];
      end
    end

    assign rd_data[p*DATA_W +: DATA_W] = data_p1;
    assign rd_busy[p]                  = busy_p1;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp at NUM_RD=4, DATA_W=64: the driver queues
// hand-computed read results, a negedge monitor pops and compares them.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int DW = 64;
  localparam int AW = 5;
  localparam int NR = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NR-1:0]     rd_en = '0;
  logic [NR*AW-1:0]  rd_addr = '0;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_busy;
  logic              wr_en = 1'b0;
  logic [1:0]        dest_sel = 2'd0;
  logic [AW-1:0]     field_rt = '0;
  logic [AW-1:0]     field_rd = '0;
  logic [DW-1:0]     wr_data = '0;
  logic              sb_set = 1'b0;
  logic [AW-1:0]     sb_addr = '0;
  logic              sb_any;

  regfile_mp #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .NUM_RD   (NR),
    .LINK_REG (31)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .dest_sel (dest_sel),
    .field_rt (field_rt),
    .field_rd (field_rd),
    .wr_data  (wr_data),
    .sb_set   (sb_set),
    .sb_addr  (sb_addr),
    .sb_any   (sb_any)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          port;
    logic [DW-1:0] data;
    logic        busy;
    logic        chk_any;
    logic        any;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int p, input logic [DW-1:0] got, input logic [DW-1:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s port%0d cyc%0d: got %h required %h", name, p, cyc, got, req);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      if (e.due != cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL late port%0d: checked at cyc %0d required cyc %0d", e.port, cyc, e.due);
      end else begin
        chk("rd_data", e.port, rd_data[e.port*DW +: DW], e.data);
        chk("rd_busy", e.port, DW'(rd_busy[e.port]), DW'(e.busy));
        if (e.chk_any) chk("sb_any", e.port, DW'(sb_any), DW'(e.any));
      end
    end
  end

  task automatic rd(input int p, input int a);
    rd_en[p] = 1'b1;
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic expect_rd(input int p, input logic [DW-1:0] d, input logic b,
                           input logic ca, input logic a);
    exp_t e;
    e.due = cyc + 1;
    e.port = p;
    e.data = d;
    e.busy = b;
    e.chk_any = ca;
    e.any = a;
    q.push_back(e);
  endtask

  task automatic wr(input int sel, input int rt, input int rdf, input logic [DW-1:0] d);
    wr_en = 1'b1;
    dest_sel = 2'(sel);
    field_rt = AW'(rt);
    field_rd = AW'(rdf);
    wr_data = d;
  endtask

  task automatic sbs(input int a);
    sb_set = 1'b1;
    sb_addr = AW'(a);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    rd_en = '0;
    wr_en = 1'b0;
    sb_set = 1'b0;
    reset = 1'b1;
  endtask

  initial begin
    // reset state
    reset = 1'b0;
    tick();
    reset = 1'b0;
    for (int p = 0; p < NR; p++) begin
      rd(p, 5);
      expect_rd(p, '0, 1'b0, 1'b1, 1'b0);
    end
    tick();

    // fill every register, chaining busy bits that the next write clears
    for (int i = 0; i < 32; i++) begin
      wr(DEST_RT, i, 0, 64'hA5A5_0000 + 64'(i));
      sbs((i + 1) % 32);
      tick();
    end
    sbs(7);
    tick();
    rd(0, 7);  expect_rd(0, 64'hA5A5_0007, 1'b1, 1'b1, 1'b1);
    rd(1, 31); expect_rd(1, 64'hA5A5_001F, 1'b0, 1'b0, 1'b0);
    rd(2, 0);  expect_rd(2, 64'h0, 1'b0, 1'b0, 1'b0);
    tick();

    // reset mid-operation, with a write, sb_set and read all discarded
    reset = 1'b0;
    wr(DEST_RT, 3, 0, 64'h55);
    sbs(4);
    rd(0, 7);
    expect_rd(0, '0, 1'b0, 1'b1, 1'b0);
    tick();
    for (int b = 0; b < 8; b++) begin
      for (int p = 0; p < NR; p++) begin
        rd(p, b * 4 + p);
        expect_rd(p, '0, 1'b0, p == 0, 1'b0);
      end
      tick();
    end

    // destination mux
    wr(DEST_RT, 8, 9, 64'h1234_5678);
    tick();
    rd(0, 8); expect_rd(0, 64'h1234_5678, 1'b0, 1'b1, 1'b0);
    rd(1, 9); expect_rd(1, 64'h0, 1'b0, 1'b0, 1'b0);
    wr(DEST_RD, 11, 10, 64'hCAFE);
    tick();
    rd(0, 10); expect_rd(0, 64'hCAFE, 1'b0, 1'b0, 1'b0);
    rd(1, 11); expect_rd(1, 64'h0, 1'b0, 1'b0, 1'b0);
    wr(DEST_LINK, 2, 3, 64'h0040_0010);
    tick();
    rd(0, 31); expect_rd(0, 64'h0040_0010, 1'b0, 1'b0, 1'b0);
    rd(1, 2);  expect_rd(1, 64'h0, 1'b0, 1'b0, 1'b0);
    rd(2, 3);  expect_rd(2, 64'h0, 1'b0, 1'b0, 1'b0);
    tick();

    // $0 is hardwired: no write, no bypass
    wr(DEST_RT, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(0, 0); expect_rd(0, 64'h0, 1'b0, 1'b0, 1'b0);
    tick();
    rd(0, 0); expect_rd(0, 64'h0, 1'b0, 1'b0, 1'b0);
    tick();

    // reserved dest_sel suppresses the write and the bypass
    wr(DEST_NONE, 8, 8, 64'hBAD);
    rd(0, 8);  expect_rd(0, 64'h1234_5678, 1'b0, 1'b0, 1'b0);
    rd(1, 31); expect_rd(1, 64'h0040_0010, 1'b0, 1'b0, 1'b0);
    tick();
    rd(0, 8); expect_rd(0, 64'h1234_5678, 1'b0, 1'b0, 1'b0);
    tick();

    // write-through bypass on two ports
    wr(DEST_RT, 5, 0, 64'hDEAD_BEEF);
    rd(0, 5); expect_rd(0, 64'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    rd(1, 5); expect_rd(1, 64'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    tick();
    rd(2, 5); expect_rd(2, 64'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    tick();

    // scoreboard
    sbs(9);
    rd(0, 9); expect_rd(0, 64'h0, 1'b0, 1'b1, 1'b1);
    tick();
    sbs(0);
    rd(0, 9); expect_rd(0, 64'h0, 1'b1, 1'b1, 1'b1);
    tick();
    rd(1, 0); expect_rd(1, 64'h0, 1'b0, 1'b1, 1'b1);
    tick();
    wr(DEST_RD, 0, 9, 64'h7);
    rd(0, 9); expect_rd(0, 64'h7, 1'b0, 1'b1, 1'b0);
    tick();
    wr(DEST_RD, 0, 9, 64'h99);
    sbs(9);
    rd(0, 9); expect_rd(0, 64'h99, 1'b0, 1'b1, 1'b1);
    tick();
    rd(0, 9); expect_rd(0, 64'h99, 1'b1, 1'b1, 1'b1);
    tick();
    wr(DEST_RD, 0, 9, 64'h99);
    tick();
    rd(0, 9); expect_rd(0, 64'h99, 1'b0, 1'b1, 1'b0);
    tick();

    // full-width data and per-port hold
    wr(DEST_RT, 12, 0, 64'h0123_4567_89AB_CDEF);
    tick();
    rd(0, 8);  expect_rd(0, 64'h1234_5678, 1'b0, 1'b0, 1'b0);
    rd(1, 10); expect_rd(1, 64'hCAFE, 1'b0, 1'b0, 1'b0);
    rd(2, 31); expect_rd(2, 64'h0040_0010, 1'b0, 1'b0, 1'b0);
    rd(3, 12); expect_rd(3, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 1'b0);
    tick();
    rd(0, 5);  expect_rd(0, 64'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    rd(1, 8);  expect_rd(1, 64'h1234_5678, 1'b0, 1'b0, 1'b0);
    rd_addr[2*AW +: AW] = AW'(9);
    expect_rd(2, 64'h0040_0010, 1'b0, 1'b0, 1'b0);
    rd(3, 10); expect_rd(3, 64'hCAFE, 1'b0, 1'b0, 1'b0);
    tick();

    tick();
    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d results still pending, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port MIPS register file that replaces the single-configuration two-port file in the decode stage. Adds configurable width, depth and read-port count, rt/rd/$ra destination selection for JAL/JALR, write-through bypass, a hardwired-zero register, and a busy-bit scoreboard for in-flight load/multicycle results. It sits between instruction decode (read addresses, destination fields) and writeback (write data), and drives the hazard unit via per-port busy flags.

## Interface
- DATA_W, 32: register width in bits.
- ADDR_W, 5: register address width; depth = 2**ADDR_W.
- NUM_RD, 2: number of read ports, 1..4.
- LINK_REG, 31: destination index used when dest_sel = LINK.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  reset, synchronous, active-low.
- rd_en  in  NUM_RD  per-port read enable.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  registered read data, packed like rd_addr.
- rd_busy  out  NUM_RD  registered: addressed register had a pending result at the read edge.
- wr_en  in  1  write enable.
- dest_sel  in  2  0 = RT, 1 = RD, 2 = LINK, 3 = reserved (no write).
- field_rt  in  ADDR_W  rt field of the instruction being written back.
- field_rd  in  ADDR_W  rd field of the instruction being written back.
- wr_data  in  DATA_W  write data.
- sb_set  in  1  mark a register pending (load/multicycle issue).
- sb_addr  in  ADDR_W  register to mark pending.
- sb_any  out  1  combinational OR of all scoreboard bits.

## Operation
- Destination address: the mux selects rt, rd or LINK_REG according to dest_sel. dest_sel = 3 suppresses the write regardless of wr_en.
- Write: on a clock edge with reset high, wr_en = 1 and a valid dest_sel, the selected register is loaded with wr_data.
- Register 0: writes are ignored, reads return 0, and it is never marked busy. sb_set to address 0 is a no-op.
- Read: for each port i with rd_en[i] = 1, rd_data[i] is loaded with the register contents.
  - If an effective write to the same address occurs in the same cycle, the port loads wr_data instead (write-through bypass).
  - For address 0 the port always loads 0.
- rd_en[i] = 0 holds rd_data[i] and rd_busy[i] unchanged.
- Scoreboard: one busy bit per register.
  - sb_set sets the bit for sb_addr.
  - An effective write clears the bit for the destination address.
  - sb_set and a write to the same address in the same cycle: set wins, the data is still written, and the bit ends at 1.
- rd_busy[i] takes the scoreboard bit for the port address after the clear from a same-cycle write is applied and before the set from a same-cycle sb_set is applied. A bypassed read therefore reports not busy.
- Reset (reset = 0 at an edge):
  - All registers are cleared to 0.
  - All busy bits are cleared to 0.
  - All rd_data are driven to 0 (never Z) and all rd_busy to 0.
  - Any same-cycle write, read or sb_set is discarded.
  - Reset asserted mid-operation behaves identically.

## Timing
- Read latency: 1 cycle. The address is presented in cycle N and the data is valid after edge N and held through cycle N+1.
- Write-to-read: 0 cycles via the bypass. A read in the same cycle as the write sees the new value.
- Scoreboard set becomes visible on rd_busy for reads issued in the cycle after sb_set.
- sb_any reflects the scoreboard state after the most recent edge, with no extra latency.
- No handshakes; every port accepts a request every cycle.

## Structure
- Shared package regfile_pkg holds:
  - dest_sel encodings DEST_RT, DEST_RD, DEST_LINK, DEST_NONE.
  - ZERO_REG = 0.
  - Default DATA_W and ADDR_W constants, shared with the decode and hazard blocks.
- Sub-module regfile_scoreboard (ADDR_W parameter) holds the busy vector with inputs set/set_addr/clr/clr_addr, per-port busy lookup and sb_any.
- Top level holds the storage array, the destination mux, the bypass compare per port, and the read registers, built with a generate loop over NUM_RD.

## Test plan
- Reset flush: fill all 32 registers with 0xA5A5_0000+i, assert reset for 1 cycle, then read each register -> every rd_data = 0, rd_busy = 0, sb_any = 0.
- Dest mux and zero:
  - dest_sel=RT, rt=8, data 0x1234_5678 -> read $8 = 0x1234_5678.
  - dest_sel=LINK, data 0x0040_0010 -> read $31 = 0x0040_0010.
  - Write $0 with 0xFFFF_FFFF -> read $0 = 0.
  - dest_sel=3 with wr_en=1 -> no register changes.
- Bypass: write $5 = 0xDEAD_BEEF while port0 and port1 both read $5 in the same cycle -> both rd_data = 0xDEAD_BEEF one cycle later; next cycle a read of $5 still returns 0xDEAD_BEEF.
- Scoreboard:
  - sb_set $9, then a read of $9 next cycle -> rd_busy = 1 and sb_any = 1.
  - Write $9 = 7 with a same-cycle read of $9 -> rd_data = 7, rd_busy = 0, sb_any = 0.
  - Simultaneous sb_set $9 and write $9 -> bit remains 1.
- Hold and parameters: with NUM_RD=4 and DATA_W=64, read distinct registers on all ports, then drop rd_en[2] while changing its address -> port 2 holds its prior value and the other ports update.
- Reset mid-operation: assert reset in the same cycle as a write $3 = 0x55 and sb_set $4 -> after release, $3 = 0 and $4 is not busy.
